core_mem_responder: RTL and testbench
=====================================

Name: core_mem_responder

Overview:
- Synchronous core-memory module that is the responder on the processor memory bus.
- The APR is the initiator: it issues read, write and read-pause-write cycles. This block acknowledges the address, returns read data and accepts write data.
- It models destructive-read core timing: read, then restore, then recovery.
- It sits beside the existing memory instances and is selected by a 4-bit module select.

Parameters:
- ADDR_W, 14, word-address width (040000 words of 36 bits).
- MODULE_SEL, 4'o0, value of membus_sel that selects this module.
- READ_CYC, 4, clocks from address acknowledge to rd_rs.
- RECOV_CYC, 3, clocks of recovery before the next request is accepted.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous reset, active-low: 0 resets the block, release is sampled on clk.
- membus_rq_cyc  in  1  request cycle level from the initiator.
- membus_rd_rq  in  1  read requested (valid with rq_cyc).
- membus_wr_rq  in  1  write requested (valid with rq_cyc).
- membus_sel  in  4  module select.
- membus_ma  in  ADDR_W  word address.
- membus_wr_rs  in  1  one-clock pulse: write data valid on membus_mb_in.
- membus_mb_in  in  36  write data, bit 0 = MSB.
- membus_addr_ack  out  1  one-clock pulse: address accepted.
- membus_rd_rs  out  1  one-clock pulse: read data valid.
- membus_mb_out  out  36  read data; held until the next cycle starts, 0 otherwise.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: state IDLE; addr_ack=0, rd_rs=0, mb_out=0, busy=0; counters and latched address/flags are cleared. Core array contents are NOT cleared.
- Reset mid-cycle: abort to IDLE. The core word being cycled keeps its pre-cycle value, because the read data is held in the buffer and never destroyed in the array until the WRITE state.
- Request acceptance, IDLE: when rq_cyc=1, membus_sel==MODULE_SEL and (rd_rq|wr_rq)=1:
  - latch ma, rd_rq and wr_rq;
  - next state ACK.
  - A request with neither rd_rq nor wr_rq set is ignored.
- ACK: addr_ack=1 for exactly 1 clock (acknowledge is 1 clk after the request is sampled). Next state:
  - READ if rd_rq;
  - otherwise WAIT_WR.
- READ: count READ_CYC-1 clocks, then load mb_out from core[ma], pulse rd_rs for 1 clock. Next state:
  - WAIT_WR if wr_rq (read-pause-write);
  - otherwise WRITE, which restores the same data.
- WAIT_WR: wait any number of clocks for wr_rs=1, then latch mb_in into the data buffer and go to WRITE. The initiator may drop rq_cyc during WAIT_WR; the block still waits. A wr_rs in any state other than WAIT_WR is ignored.
- WRITE: core[ma] <= buffer (the restored read data or the new write data), 1 clock, then RECOVER.
- RECOVER: RECOV_CYC clocks, then IDLE. Requests during RECOVER are not latched; the initiator holds rq_cyc, and the request is accepted on the first IDLE clock.
- Minimum pure-read latency: request sampled → rd_rs = 1 + READ_CYC clocks.
- Back-to-back requests: the total cycle is 1 + READ_CYC + 1 + RECOV_CYC clocks plus write wait.
- Address wrap: ma is exactly ADDR_W bits; no out-of-range case exists.
- A wrong membus_sel produces no response: no addr_ack, and the initiator's non-existent-memory timeout applies.

Optional Feature:
- Macro: CORE_MEM_SINGLE_STEP_EN.
- With it defined, two extra input ports are added: sw_single_step (1) and sw_restart (1).
  - When sw_single_step=1, the block stops in a HOLD state after WRITE instead of entering RECOVER.
  - It leaves HOLD on a rising edge of sw_restart, detected with a registered previous value.
  - busy stays 1 in HOLD.
- Without the macro, neither port exists and WRITE always goes straight to RECOVER.

Test Plan:
- Read: preload core[01000]=0123456701234; request rd_rq, sel=MODULE_SEL, ma=01000 → addr_ack 1 clk later, rd_rs READ_CYC clks after ack with mb_out=0123456701234, core[01000] unchanged afterwards.
- Write: wr_rq, ma=2, ack, then wr_rs with mb_in=0111777222666 → core[2]=0111777222666 one clk after WRITE, busy low after RECOV_CYC.
- Read-pause-write: core[5]=7; rd_rq+wr_rq → rd_rs with mb_out=7; wr_rs delayed 20 clks with mb_in=010 → core[5]=010, no second ack.
- Select mismatch: sel=MODULE_SEL^1 with rq_cyc held 50 clks → no addr_ack, busy=0, core unchanged.
- Reset abort: assert reset during WAIT_WR of a read-pause-write to address 3 holding 0777 → outputs 0 immediately, state IDLE, core[3]=0777; a fresh read returns 0777.
- Back-to-back: rq_cyc held through two reads of 10 and 11 → the second addr_ack arrives exactly 1+READ_CYC+1+RECOV_CYC+1 clks after the first.

Source files
------------

// File: rtl/core_mem_responder.sv
// ---------------------------------------------------------------------------
// core_mem_responder
//
// Core-memory responder on the processor memory bus. The APR initiates read,
// write and read-pause-write cycles; this block acknowledges the address,
// returns read data and accepts write data. The core array behaves like real
// destructive-read core: every cycle reads into a buffer, restores (or
// rewrites) the word, then spends some clocks recovering.
//
// Parameters:
//   ADDR_W     word-address width (default 14: 040000 words of 36 bits)
//   MODULE_SEL membus_sel value that addresses this module
//   READ_CYC   clocks from address acknowledge to rd_rs (must be >= 2)
//   RECOV_CYC  recovery clocks before the next request is accepted (>= 1)
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous reset, active low
//   membus_rq_cyc    request cycle level from the initiator
//   membus_rd_rq     read requested
//   membus_wr_rq     write requested
//   membus_sel       4-bit module select
//   membus_ma        word address
//   membus_wr_rs     one-clock pulse, write data valid on membus_mb_in
//   membus_mb_in     write data, bit 0 = MSB
//   membus_addr_ack  one-clock pulse, address accepted
//   membus_rd_rs     one-clock pulse, read data valid
//   membus_mb_out    read data, held until the next cycle starts, else 0
//   busy             high whenever the block is not idle
//
// Optional feature (macro CORE_MEM_SINGLE_STEP_EN): adds sw_single_step and
// sw_restart. With sw_single_step high the block parks in HOLD after WRITE
// until a rising edge on sw_restart.
// ---------------------------------------------------------------------------
module core_mem_responder #(
  parameter int unsigned ADDR_W     = 14,
  parameter logic [3:0]  MODULE_SEL = 4'o0,
  parameter int unsigned READ_CYC   = 4,
  parameter int unsigned RECOV_CYC  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              membus_rq_cyc,
  input  logic              membus_rd_rq,
  input  logic              membus_wr_rq,
  input  logic [3:0]        membus_sel,
  input  logic [ADDR_W-1:0] membus_ma,
  input  logic              membus_wr_rs,
  input  logic [0:35]       membus_mb_in,
`ifdef CORE_MEM_SINGLE_STEP_EN
  input  logic              sw_single_step,
  input  logic              sw_restart,
`endif
  output logic              membus_addr_ack,
  output logic              membus_rd_rs,
  output logic [0:35]       membus_mb_out,
  output logic              busy
);

  localparam int unsigned CNT_MAX = (READ_CYC > RECOV_CYC) ? READ_CYC : RECOV_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  // READ lasts READ_CYC clocks in total: the word is fetched at the end of
  // the second-to-last clock so rd_rs and mb_out coincide in the last one.
  localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_CYC - 2);
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_CYC - 1);
  localparam logic [CNT_W-1:0] RECOV_LAST = CNT_W'(RECOV_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    READ,
    WAIT_WR,
    WRITE,
    RECOVER
`ifdef CORE_MEM_SINGLE_STEP_EN
    , HOLD
`endif
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] ma_q;
  logic              rd_q;
  logic              wr_q;
  logic [0:35]       data_buf;
  logic [0:35]       core [0:(1<<ADDR_W)-1];
  logic              accept;

  assign accept = (state == IDLE) && membus_rq_cyc &&
                  (membus_sel == MODULE_SEL) &&
                  (membus_rd_rq || membus_wr_rq);

`ifdef CORE_MEM_SINGLE_STEP_EN
  logic restart_q;
  logic restart_rise;

  // Previous sw_restart value, so HOLD is left only on a rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) restart_q <= 1'b0;
    else        restart_q <= sw_restart;
  end

  assign restart_rise = sw_restart && !restart_q;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic for the core cycle sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ACK;
      ACK:     next_state = rd_q ? READ : WAIT_WR;
      READ:    if (cnt == READ_LAST) next_state = wr_q ? WAIT_WR : WRITE;
      WAIT_WR: if (membus_wr_rs) next_state = WRITE;
`ifdef CORE_MEM_SINGLE_STEP_EN
      WRITE:   next_state = sw_single_step ? HOLD : RECOVER;
      HOLD:    if (restart_rise) next_state = RECOVER;
`else
      WRITE:   next_state = RECOVER;
`endif
      RECOVER: if (cnt == RECOV_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Clock counter for READ and RECOVER; restarts on every state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               cnt <= '0;
    else if (next_state != state)             cnt <= '0;
    else if (state == READ || state == RECOVER) cnt <= cnt + CNT_W'(1);
  end

  // Request latch, data buffer and read-data register. mb_out is cleared
  // when a new cycle is accepted so it only shows the current cycle's word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ma_q          <= '0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      data_buf      <= '0;
      membus_mb_out <= '0;
    end else begin
      if (accept) begin
        ma_q          <= membus_ma;
        rd_q          <= membus_rd_rq;
        wr_q          <= membus_wr_rq;
        membus_mb_out <= '0;
      end
      if (state == READ && cnt == READ_LOAD) begin
        data_buf      <= core[ma_q];
        membus_mb_out <= core[ma_q];
      end
      if (state == WAIT_WR && membus_wr_rs) data_buf <= membus_mb_in;
    end
  end

  // Core array: no reset, only written in WRITE, so an aborted cycle leaves
  // the addressed word intact.
  always_ff @(posedge clk) begin
    if (state == WRITE) core[ma_q] <= data_buf;
  end

  assign membus_addr_ack = (state == ACK);
  assign membus_rd_rs    = (state == READ) && (cnt == READ_LAST);
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_core_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_core_mem_responder
//
// Directed bench for core_mem_responder. Stimulus tasks push the expected
// addr_ack / rd_rs events (kind, cycle, mb_out) into a scoreboard queue; a
// monitor on the falling edge pops and compares whenever the DUT raises one.
// ---------------------------------------------------------------------------
module tb_core_mem_responder;

  localparam int         ADDR_W     = 14;
  localparam logic [3:0] MODULE_SEL = 4'o0;
  localparam int         READ_CYC   = 4;
  localparam int         RECOV_CYC  = 3;

  logic              clk;
  logic              reset;
  logic              membus_rq_cyc;
  logic              membus_rd_rq;
  logic              membus_wr_rq;
  logic [3:0]        membus_sel;
  logic [ADDR_W-1:0] membus_ma;
  logic              membus_wr_rs;
  logic [0:35]       membus_mb_in;
  logic              membus_addr_ack;
  logic              membus_rd_rs;
  logic [0:35]       membus_mb_out;
  logic              busy;
`ifdef CORE_MEM_SINGLE_STEP_EN
  logic              sw_single_step;
  logic              sw_restart;
`endif

  typedef enum logic {EV_ACK, EV_RDRS} ev_t;
  typedef struct {
    ev_t         kind;
    logic [0:35] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fails  = 0;

  core_mem_responder #(
    .ADDR_W(ADDR_W), .MODULE_SEL(MODULE_SEL),
    .READ_CYC(READ_CYC), .RECOV_CYC(RECOV_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .membus_rq_cyc(membus_rq_cyc),
    .membus_rd_rq(membus_rd_rq),
    .membus_wr_rq(membus_wr_rq),
    .membus_sel(membus_sel),
    .membus_ma(membus_ma),
    .membus_wr_rs(membus_wr_rs),
    .membus_mb_in(membus_mb_in),
`ifdef CORE_MEM_SINGLE_STEP_EN
    .sw_single_step(sw_single_step),
    .sw_restart(sw_restart),
`endif
    .membus_addr_ack(membus_addr_ack),
    .membus_rd_rs(membus_rd_rs),
    .membus_mb_out(membus_mb_out),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish within 20000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0o, expected %0o (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushExpect(input ev_t kind, input logic [0:35] data, input int offset);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = cyc + offset;
    sb.push_back(e);
  endtask

  task automatic scoreEvent(input ev_t kind);
    exp_t  e;
    string tag;
    tag = (kind == EV_ACK) ? "addr_ack" : "rd_rs";
    if (sb.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL unexpected_%s: got event at cycle %0d, expected none", tag, cyc);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_kind"},   36'(kind), 36'(e.kind));
      checkOutput({tag, "_cycle"},  36'(cyc),  36'(e.cyc));
      checkOutput({tag, "_mb_out"}, membus_mb_out, e.data);
    end
  endtask

  // Monitor: every strobe the DUT raises must match the head of the queue.
  always @(negedge clk) begin
    if (reset) begin
      if (membus_addr_ack) scoreEvent(EV_ACK);
      if (membus_rd_rs)    scoreEvent(EV_RDRS);
    end
  end

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_idle"}, 36'(busy), 36'(0));
  endtask

  // One bus cycle. rd/wr choose read, write or read-pause-write; wdelay adds
  // idle clocks in WAIT_WR before wr_rs; abort pulls reset during WAIT_WR.
  task automatic applyStimulus(input string name, input logic rd, input logic wr,
                               input logic [ADDR_W-1:0] addr, input logic [0:35] wdata,
                               input logic [0:35] rdata, input int wdelay, input bit abort);
    @(negedge clk);
    membus_rq_cyc = 1'b1;
    membus_rd_rq  = rd;
    membus_wr_rq  = wr;
    membus_sel    = MODULE_SEL;
    membus_ma     = addr;
    pushExpect(EV_ACK, '0, 1);
    if (rd) pushExpect(EV_RDRS, rdata, 1 + READ_CYC);
    @(negedge clk);
    membus_rq_cyc = 1'b0;
    membus_rd_rq  = 1'b0;
    membus_wr_rq  = 1'b0;
    if (wr) begin
      if (rd) repeat (READ_CYC) @(negedge clk);
      repeat (wdelay + 1) @(negedge clk);
      if (abort) begin
        reset = 1'b0;
        #1;
        checkOutput({name, "_rst_ack"},    36'(membus_addr_ack), 36'(0));
        checkOutput({name, "_rst_rd_rs"},  36'(membus_rd_rs),    36'(0));
        checkOutput({name, "_rst_mb_out"}, membus_mb_out,        36'(0));
        checkOutput({name, "_rst_busy"},   36'(busy),            36'(0));
        @(negedge clk);
        reset = 1'b1;
      end else begin
        membus_mb_in = wdata;
        membus_wr_rs = 1'b1;
        @(negedge clk);
        membus_wr_rs = 1'b0;
        membus_mb_in = '0;
        repeat (RECOV_CYC) @(negedge clk);
        checkOutput({name, "_busy_recover"}, 36'(busy), 36'(1));
        @(negedge clk);
        checkOutput({name, "_busy_done"}, 36'(busy), 36'(0));
      end
    end else begin
      waitIdle(name);
    end
  endtask

  task automatic holdForeign(input string name, input logic [3:0] sel,
                             input logic rd, input logic wr, input int clocks);
    int busy_cnt;
    busy_cnt = 0;
    @(negedge clk);
    membus_rq_cyc = 1'b1;
    membus_rd_rq  = rd;
    membus_wr_rq  = wr;
    membus_sel    = sel;
    membus_ma     = 14'o1000;
    for (int i = 0; i < clocks; i++) begin
      membus_wr_rs = (i % 7 == 3);
      membus_mb_in = 36'o777777777777;
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    membus_rq_cyc = 1'b0;
    membus_rd_rq  = 1'b0;
    membus_wr_rq  = 1'b0;
    membus_wr_rs  = 1'b0;
    membus_mb_in  = '0;
    membus_sel    = MODULE_SEL;
    checkOutput({name, "_busy_cycles"}, 36'(busy_cnt), 36'(0));
  endtask

  initial begin
    reset         = 1'b0;
    membus_rq_cyc = 1'b0;
    membus_rd_rq  = 1'b0;
    membus_wr_rq  = 1'b0;
    membus_sel    = MODULE_SEL;
    membus_ma     = '0;
    membus_wr_rs  = 1'b0;
    membus_mb_in  = '0;
`ifdef CORE_MEM_SINGLE_STEP_EN
    sw_single_step = 1'b0;
    sw_restart     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset_addr_ack", 36'(membus_addr_ack), 36'(0));
    checkOutput("reset_rd_rs",    36'(membus_rd_rs),    36'(0));
    checkOutput("reset_mb_out",   membus_mb_out,        36'(0));
    checkOutput("reset_busy",     36'(busy),            36'(0));
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] preload by bus writes");
    applyStimulus("pre1000", 0, 1, 14'o1000, 36'o123456701234, '0, 0, 0);
    applyStimulus("pre5",    0, 1, 14'o5,    36'o7,            '0, 1, 0);
    applyStimulus("pre3",    0, 1, 14'o3,    36'o777,          '0, 2, 0);
    applyStimulus("pre10",   0, 1, 14'o10,   36'o555000111222, '0, 0, 0);
    applyStimulus("pre11",   0, 1, 14'o11,   36'o666000333444, '0, 0, 0);

    $display("[TB] read and restore");
    applyStimulus("rd1000a", 1, 0, 14'o1000, '0, 36'o123456701234, 0, 0);
    applyStimulus("rd1000b", 1, 0, 14'o1000, '0, 36'o123456701234, 0, 0);

    $display("[TB] write");
    applyStimulus("wr2",     0, 1, 14'o2, 36'o111777222666, '0, 3, 0);
    applyStimulus("rd2",     1, 0, 14'o2, '0, 36'o111777222666, 0, 0);

    $display("[TB] read-pause-write");
    applyStimulus("rpw5",    1, 1, 14'o5, 36'o10, 36'o7, 20, 0);
    applyStimulus("rd5",     1, 0, 14'o5, '0, 36'o10, 0, 0);

    $display("[TB] select mismatch and empty request");
    holdForeign("selmis", MODULE_SEL ^ 4'd1, 1, 1, 50);
    applyStimulus("rd1000c", 1, 0, 14'o1000, '0, 36'o123456701234, 0, 0);
    holdForeign("norq", MODULE_SEL, 0, 0, 10);

    $display("[TB] reset abort");
    applyStimulus("abort3",  1, 1, 14'o3, 36'o1234, 36'o777, 4, 1);
    applyStimulus("rd3",     1, 0, 14'o3, '0, 36'o777, 0, 0);

    $display("[TB] back-to-back reads");
    @(negedge clk);
    membus_rq_cyc = 1'b1;
    membus_rd_rq  = 1'b1;
    membus_wr_rq  = 1'b0;
    membus_sel    = MODULE_SEL;
    membus_ma     = 14'o10;
    pushExpect(EV_ACK,  '0,              1);
    pushExpect(EV_RDRS, 36'o555000111222, 1 + READ_CYC);
    pushExpect(EV_ACK,  '0,              1 + READ_CYC + 1 + RECOV_CYC + 1 + 1);
    pushExpect(EV_RDRS, 36'o666000333444, 1 + READ_CYC + 1 + RECOV_CYC + 1 + 1 + READ_CYC);
    @(negedge clk);
    membus_ma = 14'o11;
    repeat (1 + READ_CYC + 1 + RECOV_CYC + 1) @(negedge clk);
    membus_rq_cyc = 1'b0;
    membus_rd_rq  = 1'b0;
    waitIdle("b2b");

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", 36'(sb.size()), 36'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
